// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD async reads, two prioritised writes, bulk-clear sweep.
// Optional RF_BYPASS_EN macro forwards same-cycle write data to matching read ports.
module register_file_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RD*AW-1:0] ra,
  output logic [NUM_RD*DW-1:0] rd,
  input  logic                 we0,
  input  logic [AW-1:0]        wa0,
  input  logic [DW-1:0]        wd0,
  input  logic                 we1,
  input  logic [AW-1:0]        wa1,
  input  logic [DW-1:0]        wd1,
  input  logic                 clr,
  output logic                 busy,
  output logic                 clr_done
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_mem [DEPTH];

  logic w_idle;
  logic w_wr0;
  logic w_wr1;
  logic w_last;

  assign w_idle = (r_state == S_IDLE);
  assign w_last = (r_cnt == AW'(DEPTH - 1));

  // Writes only land in IDLE; entry 0 is read-only when hardwired to zero.
  assign w_wr0 = w_idle && we0 &&
                 !((ZERO_REG != 0) && (wa0 == '0));
  assign w_wr1 = w_idle && we1 &&
                 !((ZERO_REG != 0) && (wa1 == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    clr_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clr) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        clr_done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Port 1 is assigned last so it wins on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_wr0) begin
        r_mem[wa0] <= wd0;
      end
      if (w_wr1) begin
        r_mem[wa1] <= wd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [DW-1:0] w_rd;

    assign w_ra = ra[k*AW +: AW];

    always_comb begin
      w_rd = r_mem[w_ra];
`ifdef RF_BYPASS_EN
      if (w_wr0 && (wa0 == w_ra)) begin
        w_rd = wd0;
      end
      if (w_wr1 && (wa1 == w_ra)) begin
        w_rd = wd1;
      end
`endif
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_rd = '0;
      end
    end

    assign rd[k*DW +: DW] = w_rd;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp.
// Covers reset, dual write priority, zero register, clear sweep and mid-sweep reset.
module tb_register_file_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [63:0] rd_nz;
  logic        we0;
  logic [4:0]  wa0;
  logic [31:0] wd0;
  logic        we1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic        clr;
  logic        busy;
  logic        clr_done;
  logic        busy_nz;
  logic        done_nz;

  int n_chk;
  int n_pass;

  register_file_mp u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rd       (rd),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .clr      (clr),
    .busy     (busy),
    .clr_done (clr_done)
  );

  register_file_mp #(.ZERO_REG(0)) u_dut_nz (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rd       (rd_nz),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .clr      (clr),
    .busy     (busy_nz),
    .clr_done (done_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int p,
                        input logic [4:0] a,
                        input logic [31:0] exp);
    ra[p*5 +: 5] = a;
    #1;
    chk(tag, rd[p*32 +: 32], exp);
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we0 = 1'b1;
    wa0 = a;
    wd0 = d;
    @(negedge clk);
    we0 = 1'b0;
  endtask

  initial begin
    int n;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    ra     = '0;
    we0    = 1'b0;
    wa0    = '0;
    wd0    = '0;
    we1    = 1'b0;
    wa1    = '0;
    wd1    = '0;
    clr    = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    chk("rst_busy_nz", 32'(busy_nz | done_nz), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd_chk("rst_rd", 0, 5'(i), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    wr0(5'd7, 32'hDEADBEEF);
    rd_chk("wr7_p0", 0, 5'd7, 32'hDEADBEEF);
    rd_chk("wr7_p1", 1, 5'd7, 32'hDEADBEEF);

    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1111;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h2222;
    @(negedge clk);
    wa0 = 5'd3; wd0 = 32'hAAAA;
    wa1 = 5'd4; wd1 = 32'hBBBB;
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0;
    rd_chk("prio_5", 0, 5'd5, 32'h2222);
    rd_chk("dual_3", 0, 5'd3, 32'hAAAA);
    rd_chk("dual_4", 1, 5'd4, 32'hBBBB);

    wr0(5'd0, 32'hFFFFFFFF);
    rd_chk("zero_reg", 0, 5'd0, 32'h0);
    chk("nonzero_reg", rd_nz[31:0], 32'hFFFFFFFF);

    @(negedge clk);
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hCAFE;
    ra[9:5] = 5'd9;
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_same", rd[63:32], 32'hCAFE);
`else
    chk("bypass_same", rd[63:32], 32'h0);
`endif
    @(negedge clk);
    we1 = 1'b0;
    chk("bypass_after", rd[63:32], 32'hCAFE);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      we0 = 1'b1;
      wa0 = 5'(i);
      wd0 = 32'h100 + 32'(i);
    end
    @(negedge clk);
    we0 = 1'b0;
    rd_chk("fill_31", 0, 5'd31, 32'h11F);
    rd_chk("fill_0", 1, 5'd0, 32'h0);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 5) begin
        rd_chk("mid_31", 1, 5'd31, 32'h11F);
        we0 = 1'b1; wa0 = 5'd31; wd0 = 32'h5555;
        we1 = 1'b1; wa1 = 5'd2;  wd1 = 32'h6666;
        clr = 1'b1;
      end
      if (n == 6) begin
        we0 = 1'b0; we1 = 1'b0; clr = 1'b0;
      end
      if (n == 20) begin
        rd_chk("mid_swept", 0, 5'd10, 32'h0);
        rd_chk("mid_unswept", 1, 5'd25, 32'h119);
      end
      @(negedge clk);
    end
    chk("busy_len", 32'(n), 32'd32);
    chk("done_pulse", 32'(clr_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_once", 32'(clr_done), 32'd0);
    rd_chk("clr_31", 0, 5'd31, 32'h0);
    rd_chk("clr_2", 1, 5'd2, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd_chk("clr_all", 0, 5'(i), 32'h0);
    end

    wr0(5'd20, 32'h77);
    rd_chk("pre_20", 0, 5'd20, 32'h77);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      n++;
      if (n < 10) begin
        @(negedge clk);
      end
    end
    chk("sweep_cyc10", 32'(n), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(clr_done), 32'd0);
    rd_chk("arst_20", 0, 5'd20, 32'h0);
    rd_chk("arst_nz0", 1, 5'd0, 32'h0);
    chk("arst_nz_rd0", rd_nz[63:32], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66;
    @(negedge clk);
    we0 = 1'b0;
    rd_chk("post_rst_wr", 0, 5'd6, 32'h66);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
